// File: rtl/rle_decompressor.sv
// ----------------------------------------------------------------------------
// rle_decompressor
//
// Expands a compressed stream of (count, value) byte pairs into individual
// bytes. Each expanded byte is presented with a sequential RAM write address
// to the decompressed-data input of the RAM write multiplexer. A count byte of
// zero ends the stream. A run also ends when the last RAM address has been
// written.
//
// Ports:
//    clk_i          sole clock, rising edge
//    rst_i          synchronous active-high reset
//    start_i        arms a new run; honoured only in IDLE or DONE
//    in_data_i      compressed stream byte
//    in_valid_i     in_data_i is valid
//    in_ready_o     block accepts in_data_i this cycle
//    out_data_o     decompressed byte (DataInDecompressed of the mux)
//    out_addr_o     RAM write address for out_data_o
//    out_valid_o    out_data_o / out_addr_o are valid
//    out_ready_i    downstream accepts the output this cycle
//    done_o         run finished
//    overflow_o     run truncated because RAM filled; sticky until start/reset
//    word_count_o   bytes written since the last start
// ----------------------------------------------------------------------------
module rle_decompressor #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [7:0]        in_data_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic [7:0]        out_data_o,
   output logic [ADDR_W-1:0] out_addr_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic              done_o,
   output logic              overflow_o,
   output logic [ADDR_W:0]   word_count_o
);

   typedef enum logic [2:0] {
      IDLE,
      GET_COUNT,
      GET_VALUE,
      EMIT,
      DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state_q;
   logic [7:0]        remaining_q;
   logic [7:0]        value_q;
   logic [ADDR_W-1:0] outAddr_q;
   logic [ADDR_W:0]   wordCount_q;
   logic              inReady_q;
   logic              outValid_q;
   logic              done_q;
   logic              overflow_q;

   logic [ADDR_W-1:0] addrInc_d;
   logic [ADDR_W:0]   wordInc_d;
   logic [7:0]        remDec_d;

   // Incremented/decremented copies of the counters used by the EMIT state.
   assign addrInc_d = outAddr_q + ADDR_W'(1);
   assign wordInc_d = wordCount_q + (ADDR_W + 1)'(1);
   assign remDec_d  = remaining_q - 8'd1;

   // Whole controller in one clocked block. The handshake flags (inReady_q,
   // outValid_q, done_q) are updated together with the state so they are
   // pure flops and never depend combinationally on in_valid_i/out_ready_i.
   // When the final RAM address is written the address register is left at
   // DEPTH-1 instead of being incremented, so it cannot wrap to zero when
   // DEPTH equals 2^ADDR_W; word_count still records the full byte count.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         remaining_q <= 8'd0;
         value_q     <= 8'd0;
         outAddr_q   <= '0;
         wordCount_q <= '0;
         inReady_q   <= 1'b0;
         outValid_q  <= 1'b0;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  outAddr_q   <= '0;
                  wordCount_q <= '0;
                  overflow_q  <= 1'b0;
                  inReady_q   <= 1'b1;
                  done_q      <= 1'b0;
                  state_q     <= GET_COUNT;
               end
            end

            GET_COUNT: begin
               if (in_valid_i) begin
                  if (in_data_i == 8'd0) begin
                     inReady_q <= 1'b0;
                     done_q    <= 1'b1;
                     state_q   <= DONE;
                  end else begin
                     remaining_q <= in_data_i;
                     state_q     <= GET_VALUE;
                  end
               end
            end

            GET_VALUE: begin
               if (in_valid_i) begin
                  value_q    <= in_data_i;
                  inReady_q  <= 1'b0;
                  outValid_q <= 1'b1;
                  state_q    <= EMIT;
               end
            end

            EMIT: begin
               if (out_ready_i) begin
                  wordCount_q <= wordInc_d;
                  remaining_q <= remDec_d;
                  if (outAddr_q == LAST_ADDR) begin
                     outValid_q <= 1'b0;
                     done_q     <= 1'b1;
                     overflow_q <= (remaining_q > 8'd1);
                     state_q    <= DONE;
                  end else begin
                     outAddr_q <= addrInc_d;
                     if (remaining_q == 8'd1) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= GET_COUNT;
                     end
                  end
               end
            end

            default: begin
               inReady_q  <= 1'b0;
               outValid_q <= 1'b0;
               done_q     <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign in_ready_o   = inReady_q;
   assign out_valid_o  = outValid_q;
   assign done_o       = done_q;
   assign overflow_o   = overflow_q;
   assign out_data_o   = value_q;
   assign out_addr_o   = outAddr_q;
   assign word_count_o = wordCount_q;

endmodule

// File: tb/tb_rle_decompressor.sv
// ----------------------------------------------------------------------------
// tb_rle_decompressor
//
// Self-checking bench for rle_decompressor. A small RAM (DEPTH=16) is used so
// that the full-memory paths are reachable with short streams. Expected output
// bytes, addresses, final counts and the number of consumed input bytes come
// from a plain queue-based expansion of the stream.
// ----------------------------------------------------------------------------
module tb_rle_decompressor;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst_i;
   logic              start_i;
   logic [7:0]        in_data_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [7:0]        out_data_o;
   logic [ADDR_W-1:0] out_addr_o;
   logic              out_valid_o;
   logic              out_ready_i;
   logic              done_o;
   logic              overflow_o;
   logic [ADDR_W:0]   word_count_o;

   int vectors     = 0;
   int miscompares = 0;

   // Expected results of the stream currently being run.
   logic [7:0]        expData[$];
   logic [ADDR_W-1:0] expAddr[$];
   logic [ADDR_W:0]   expWords;
   logic              expOverflow;
   int                expConsumed;

   always #5 clk = ~clk;

   rle_decompressor #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .in_data_i   (in_data_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .out_data_o  (out_data_o),
      .out_addr_o  (out_addr_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .done_o      (done_o),
      .overflow_o  (overflow_o),
      .word_count_o(word_count_o)
   );

   // Expand a stream the way the format defines it: each (C, V) pair gives C
   // copies of V at consecutive addresses, C=0 ends the stream, and writing
   // address DEPTH-1 ends it immediately (overflow if copies were left over).
   function automatic void buildModel(input logic [7:0] s[$]);
      int  i    = 0;
      int  addr = 0;
      bit  stop = 0;
      int  c;
      logic [7:0] v;
      expData.delete();
      expAddr.delete();
      expOverflow = 1'b0;
      while (!stop && i < s.size()) begin
         c = int'(s[i]);
         i++;
         if (c == 0) break;
         if (i >= s.size()) break;
         v = s[i];
         i++;
         for (int k = 1; k <= c; k++) begin
            expData.push_back(v);
            expAddr.push_back(ADDR_W'(addr));
            addr++;
            if (addr == DEPTH) begin
               expOverflow = (k < c);
               stop = 1;
               break;
            end
         end
      end
      expWords    = (ADDR_W + 1)'(addr);
      expConsumed = i;
   endfunction

   // Start a run, feed the stream with the chosen input gaps and output-ready
   // pattern (0: always ready, 1: 1,0,0 repeating, 2: random), and check
   // every output transfer, stall stability, value-to-output latency and the
   // final state. abortAfter>0 stops right after that many output transfers.
   task automatic runStream(input string tag, input logic [7:0] s[$],
                            input int gapMin, input int gapMax,
                            input int readyMode, input bit startNoise,
                            input int abortAfter);
      int   idx         = 0;
      int   gap         = 0;
      int   cyc         = 0;
      int   xfers       = 0;
      int   valueCycle  = -10;
      bit   nextIsValue = 0;
      bit   prevStall   = 0;
      bit   stopNow     = 0;
      bit   finished    = 0;
      logic [7:0]        prevData = '0;
      logic [ADDR_W-1:0] prevAddr = '0;

      buildModel(s);
      gap = int'($urandom_range(gapMax, gapMin));

      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;

      vectors++;
      if (word_count_o !== '0) begin
         miscompares++;
         $display("[TB] FAIL %s start_wc: got %0d expected 0", tag, word_count_o);
      end
      vectors++;
      if (overflow_o !== 1'b0 || in_ready_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL %s start_state: got ovf=%b rdy=%b expected ovf=0 rdy=1",
                  tag, overflow_o, in_ready_o);
      end

      while (!finished) begin
         if (done_o === 1'b1) begin
            finished = 1;
            break;
         end
         if (cyc >= 2000) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s timeout: got no done after %0d cycles expected done", tag, cyc);
            break;
         end

         if (cyc == valueCycle + 1) begin
            vectors++;
            if (out_valid_o !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL %s latency: got out_valid=%b expected 1", tag, out_valid_o);
            end
         end
         if (out_valid_o === 1'b1) begin
            vectors++;
            if (in_ready_o !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL %s emit_in_ready: got %b expected 0", tag, in_ready_o);
            end
         end
         if (prevStall) begin
            vectors++;
            if (out_valid_o !== 1'b1 || out_data_o !== prevData || out_addr_o !== prevAddr) begin
               miscompares++;
               $display("[TB] FAIL %s stall_hold: got v=%b d=%h a=%0d expected v=1 d=%h a=%0d",
                        tag, out_valid_o, out_data_o, out_addr_o, prevData, prevAddr);
            end
         end

         if (gap > 0) begin
            in_valid_i = 1'b0;
            gap--;
         end else if (idx < s.size()) begin
            in_valid_i = 1'b1;
            in_data_i  = s[idx];
         end else begin
            in_valid_i = 1'b0;
         end
         case (readyMode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = (cyc % 3 == 0);
            default: out_ready_i = 1'($urandom_range(0, 1));
         endcase
         start_i = startNoise ? 1'($urandom_range(0, 1)) : 1'b0;

         if (in_valid_i === 1'b1 && in_ready_o === 1'b1) begin
            if (nextIsValue) begin
               valueCycle  = cyc;
               nextIsValue = 0;
            end else if (in_data_i != 8'd0) begin
               nextIsValue = 1;
            end
            idx++;
            gap = int'($urandom_range(gapMax, gapMin));
         end
         if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
            vectors++;
            if (expData.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL %s extra_write: got d=%h a=%0d expected no write",
                        tag, out_data_o, out_addr_o);
            end else begin
               if (out_data_o !== expData[0] || out_addr_o !== expAddr[0]) begin
                  miscompares++;
                  $display("[TB] FAIL %s write: got d=%h a=%0d expected d=%h a=%0d",
                           tag, out_data_o, out_addr_o, expData[0], expAddr[0]);
               end
               void'(expData.pop_front());
               void'(expAddr.pop_front());
            end
            xfers++;
            if (abortAfter > 0 && xfers == abortAfter) stopNow = 1;
         end

         prevStall = (out_valid_o === 1'b1) && (out_ready_i === 1'b0);
         prevData  = out_data_o;
         prevAddr  = out_addr_o;
         @(negedge clk);
         cyc++;
         if (stopNow) break;
      end

      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      start_i     = 1'b0;

      if (abortAfter == 0) begin
         vectors++;
         if (done_o !== 1'b1 || in_ready_o !== 1'b0 || out_valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s done_state: got done=%b rdy=%b v=%b expected done=1 rdy=0 v=0",
                     tag, done_o, in_ready_o, out_valid_o);
         end
         vectors++;
         if (expData.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL %s missing_writes: got %0d left expected 0", tag, expData.size());
         end
         vectors++;
         if (word_count_o !== expWords) begin
            miscompares++;
            $display("[TB] FAIL %s word_count: got %0d expected %0d", tag, word_count_o, expWords);
         end
         vectors++;
         if (overflow_o !== expOverflow) begin
            miscompares++;
            $display("[TB] FAIL %s overflow: got %b expected %b", tag, overflow_o, expOverflow);
         end
         vectors++;
         if (idx != expConsumed) begin
            miscompares++;
            $display("[TB] FAIL %s consumed: got %0d expected %0d", tag, idx, expConsumed);
         end
      end
   endtask

   // Reset state, and reset winning over a simultaneous start.
   task automatic test_reset();
      rst_i = 1'b1;
      start_i = 1'b0;
      in_valid_i = 1'b0;
      in_data_i = 8'h00;
      out_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0 || done_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: got rdy=%b v=%b done=%b expected 0 0 0",
                  in_ready_o, out_valid_o, done_o);
      end
      vectors++;
      if (overflow_o !== 1'b0 || out_data_o !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL reset_ovf_data: got ovf=%b d=%h expected 0 00", overflow_o, out_data_o);
      end
      vectors++;
      if (out_addr_o !== '0 || word_count_o !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_counts: got a=%0d wc=%0d expected 0 0", out_addr_o, word_count_o);
      end
      start_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      start_i = 1'b0;
      vectors++;
      if (in_ready_o !== 1'b0 || done_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_vs_start: got rdy=%b done=%b expected 0 0", in_ready_o, done_o);
      end
   endtask

   task automatic test_basic_pairs();
      logic [7:0] st[$];
      st = '{8'h03, 8'hAA, 8'h02, 8'h55, 8'h00};
      runStream("basic", st, 0, 0, 0, 1'b0, 0);
      vectors++;
      if (out_addr_o !== ADDR_W'(5)) begin
         miscompares++;
         $display("[TB] FAIL basic_final_addr: got %0d expected 5", out_addr_o);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] st[$];
      st = '{8'h04, 8'h11, 8'h00};
      runStream("backpressure", st, 0, 0, 1, 1'b0, 0);
   endtask

   // 14 bytes of 01 then a run of six 7E: only two fit before RAM is full.
   task automatic test_overflow();
      logic [7:0] st[$];
      st = '{8'h0E, 8'h01, 8'h06, 8'h7E, 8'h00};
      runStream("overflow", st, 0, 0, 0, 1'b0, 0);
      st = '{8'h01, 8'h22, 8'h00};
      runStream("after_overflow", st, 0, 0, 0, 1'b0, 0);
   endtask

   // 12 + 4 bytes fill RAM exactly; the trailing 00 must stay unconsumed.
   task automatic test_exact_fill();
      logic [7:0] st[$];
      st = '{8'h0C, 8'h05, 8'h04, 8'h33, 8'h00};
      runStream("exact_fill", st, 0, 0, 0, 1'b0, 0);
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] st[$];
      st = '{8'hFF, 8'h01};
      runStream("mid_run", st, 0, 0, 0, 1'b0, 10);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      vectors++;
      if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0 || done_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midrst_flags: got rdy=%b v=%b done=%b expected 0 0 0",
                  in_ready_o, out_valid_o, done_o);
      end
      vectors++;
      if (overflow_o !== 1'b0 || out_data_o !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL midrst_ovf_data: got ovf=%b d=%h expected 0 00", overflow_o, out_data_o);
      end
      vectors++;
      if (out_addr_o !== '0 || word_count_o !== '0) begin
         miscompares++;
         $display("[TB] FAIL midrst_counts: got a=%0d wc=%0d expected 0 0", out_addr_o, word_count_o);
      end
      st = '{8'h01, 8'h22, 8'h00};
      runStream("after_reset", st, 0, 0, 0, 1'b0, 0);
   endtask

   task automatic test_idle_gaps();
      logic [7:0] st[$];
      st = '{8'h02, 8'h9C, 8'h00};
      runStream("idle_gaps", st, 3, 3, 0, 1'b0, 0);
   endtask

   // Random pair streams with random gaps, random backpressure and start
   // pulses that must be ignored while a run is in progress.
   task automatic test_random();
      logic [7:0] st[$];
      int npairs;
      for (int it = 0; it < 25; it++) begin
         st.delete();
         npairs = int'($urandom_range(1, 6));
         for (int p = 0; p < npairs; p++) begin
            st.push_back(8'($urandom_range(1, 8)));
            st.push_back(8'($urandom_range(0, 255)));
         end
         st.push_back(8'h00);
         runStream($sformatf("random%0d", it), st, 0, int'($urandom_range(0, 2)),
                   2, 1'($urandom_range(0, 1)), 0);
      end
   endtask

   initial begin
      test_reset();
      test_basic_pairs();
      test_backpressure();
      test_overflow();
      test_exact_fill();
      test_reset_mid_run();
      test_idle_gaps();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rle_decompressor.md
# rle_decompressor

Run-length decompressor feeding the decompressed-data input of the RAM write multiplexer (the path selected when Load=1, Image=0, Layer=0). It consumes a compressed byte stream of (count, value) pairs and expands each pair into `count` copies of `value`. Each expanded byte is presented with a sequential RAM write address and a valid/ready handshake. It stops on an end-of-stream marker or when the target memory is full.

## Interface
- `DEPTH`, default 1024: number of RAM words addressable; the last writable address is DEPTH-1.
- `ADDR_W`, default 10: address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- `clk`  input  1  sole clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  arms decompression; honoured only in IDLE or DONE.
- `in_data`  input  8  compressed stream byte.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  block accepts `in_data` this cycle.
- `out_data`  output  8  decompressed byte; drives the mux's DataInDecompressed.
- `out_addr`  output  ADDR_W  RAM write address for `out_data`.
- `out_valid`  output  1  `out_data`/`out_addr` are valid.
- `out_ready`  input  1  downstream accepts the output this cycle.
- `done`  output  1  decompression finished; high in DONE.
- `overflow`  output  1  the stream was truncated because RAM was full; sticky until the next `start` or `rst`.
- `word_count`  output  ADDR_W+1  number of bytes written since the last `start`.

## Operation
- **Stream format:** a count byte C is followed by a value byte V.
  - C=1..255 emits V exactly C times.
  - C=0 is the end-of-stream marker; no value byte follows it.
- **Handshakes:** an input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- **IDLE:** all outputs are 0. `start` clears `out_addr`, `word_count` and `overflow`, then moves to GET_COUNT.
- **GET_COUNT:** `in_ready`=1.
  - On a transfer with `in_data`=0, go to DONE.
  - On a transfer with any other value, latch it into `remaining`, then go to GET_VALUE.
- **GET_VALUE:** `in_ready`=1. On a transfer, latch `in_data` into the `value` register, then go to EMIT.
- **EMIT:** `in_ready`=0, `out_valid`=1, `out_data`=`value`, `out_addr`=current address. On each output transfer, `out_addr`, `word_count` and `remaining` update as follows:
  - `out_addr` increments by 1.
  - `word_count` increments by 1.
  - `remaining` decrements by 1.
  - If the transfer was at address DEPTH-1, go to DONE. Set `overflow`=1 if `remaining` was greater than 1 before the decrement.
  - Otherwise, if `remaining` was 1, go to GET_COUNT.
  - Otherwise, stay in EMIT.
- **DONE:** `done`=1 and `in_ready`=0.
  - `out_addr` and `word_count` hold their final values.
  - `start` clears the counters and `overflow`, then moves to GET_COUNT.
- **Ignored inputs:** `start` is ignored in GET_COUNT, GET_VALUE and EMIT. Input bytes offered while `in_ready`=0 are not consumed.
- **Full RAM at a pair boundary:** a pair that exactly fills address DEPTH-1 ends in DONE with `overflow`=0. The end marker is then not consumed.
- **Address width:** `out_addr` never wraps. Reaching DEPTH always terminates the run.

## Timing
- `in_ready`, `out_valid` and `done` are decoded from registered state only. None of them depends combinationally on `in_valid` or `out_ready`.
- **Latency:** the value byte is accepted at edge t, and the first `out_valid` is high in the cycle after edge t.
- **Throughput:** one output byte per cycle while `out_ready`=1. Each pair costs C+2 cycles minimum.
- **Stall:** while `out_ready`=0 in EMIT, `out_data`, `out_addr` and `out_valid` hold stable.
- **Reset:** `rst`=1 at any edge, including mid-EMIT, forces IDLE. After reset all outputs are 0: `in_ready`, `out_valid`, `done`, `overflow`, `out_data`, `out_addr` and `word_count`.
- **`rst` and `start` together:** `rst` wins.

## Test plan
- **Basic pairs:** `start`, then stream 03 AA 02 55 00 with `out_ready`=1. Required:
  - Output bytes AA, AA, AA, 55, 55 at addresses 0–4.
  - `done`=1, `word_count`=5, `overflow`=0.
  - First `out_valid` one cycle after AA is accepted.
- **Backpressure:** stream 04 11 00 with `out_ready` toggling 1,0,0,1,… Required:
  - Exactly four transfers at addresses 0–3.
  - Data and address held stable during stall cycles.
  - No input is consumed during EMIT.
- **Overflow:** DEPTH=4, stream 06 7E. Required:
  - Four writes at addresses 0–3, then DONE.
  - `overflow`=1, `word_count`=4.
  - A later `start` clears `overflow` and `word_count`.
- **Exact fill:** DEPTH=4, stream 04 33 00. Required:
  - Four writes, then DONE with `overflow`=0.
  - `in_ready`=0 in DONE, so the 00 byte is not consumed.
- **Reset mid-run:** stream FF 01, assert `rst` after 10 output transfers. Required:
  - The next cycle has all outputs 0 and the block is in IDLE.
  - A new `start` with 01 22 00 writes 22 at address 0.
- **Idle input gaps:** stream 02 9C 00 with `in_valid` low for 3 cycles between bytes. Required:
  - The block waits in GET_COUNT/GET_VALUE.
  - Output is 9C, 9C at addresses 0–1, then `done`=1.
